axi_r_gen: RTL and testbench
============================

Name: axi_r_gen

Overview:
- AXI4 read-response generator: the slave end of the read channel, sitting between an AXI read-address (AR) interface and a simple single-port memory read interface.
- Accepts one AR burst at a time and issues one memory read per beat.
- Returns each beat on the R channel with resp, id and user, and flags the final beat with last.
- Feeds a master-side R buffer upstream; one beat in flight, no outstanding-transaction reordering.

Parameters:
ID_WIDTH, 4, AR/R id width
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, R data / memory data width (power of two, >=8)
USER_WIDTH, 6, AR/R user width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ar_valid_i  in  1  AR request valid
ar_addr_i  in  ADDR_WIDTH  start byte address
ar_len_i  in  8  beats minus one
ar_size_i  in  3  log2 bytes per beat
ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
ar_id_i  in  ID_WIDTH  transaction id
ar_user_i  in  USER_WIDTH  user sideband
ar_ready_o  out  1  AR accepted
r_valid_o  out  1  R beat valid
r_data_o  out  DATA_WIDTH  read data
r_resp_o  out  2  00 OKAY, 10 SLVERR
r_id_o  out  ID_WIDTH  id echoed from AR
r_user_o  out  USER_WIDTH  user echoed from AR
r_last_o  out  1  final beat of burst
r_ready_i  in  1  R beat accepted
mem_req_o  out  1  memory read request
mem_addr_o  out  ADDR_WIDTH  memory byte address
mem_gnt_i  in  1  request granted
mem_rvalid_i  in  1  read data valid (any cycle >=1 after grant)
mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Reset (asynchronous, active-low): state IDLE; ar_ready_o=1; r_valid_o=0, r_last_o=0, r_resp_o=0, r_data_o/id/user=0; mem_req_o=0, mem_addr_o=0; beat counter=0.
- FSM states: IDLE, REQ, WAIT, SEND, ERR.
- IDLE:
  - ar_ready_o=1; on ar_valid_i, capture addr/len/size/burst/id/user and clear beat counter.
  - Burst is illegal if ar_burst_i is WRAP or 11, or if ar_size_i > log2(DATA_WIDTH/8). Illegal -> ERR; legal -> REQ.
  - ar_ready_o=0 in every other state.
- REQ: mem_req_o=1 with mem_addr_o=current address, held stable until mem_gnt_i; on grant -> WAIT.
- WAIT: on mem_rvalid_i, register mem_rdata_i into r_data_o, r_resp_o=OKAY -> SEND.
- SEND:
  - r_valid_o=1; r_last_o = (beat counter == len).
  - All R outputs held stable until r_ready_i.
  - On handshake: if last -> IDLE; else increment counter, update address, -> REQ.
- ERR:
  - Emits len+1 beats with r_valid_o=1, r_resp_o=SLVERR, r_data_o=0; no memory access.
  - r_last_o on the final beat; -> IDLE after the last handshake.
- Address update: INCR next = (addr & ~((1<<size)-1)) + (1<<size), wrapping modulo 2^ADDR_WIDTH; FIXED keeps the address unchanged.
- Latency, zero-wait memory: AR handshake at cycle 0, mem_req_o at cycle 1, grant at 1, rvalid at 2, r_valid_o at 3. Each additional beat costs 3 cycles when r_ready_i=1.
- r_id_o and r_user_o equal the captured AR values for every beat of the burst.
- mem_rvalid_i outside WAIT is ignored. After reset mid-burst, no further beats are emitted for the aborted burst and any late mem_rvalid_i is discarded.
- len=255 is supported: the 8-bit counter reaches 255 with no overflow before last.

Optional Feature:
- Macro AXI_R_GEN_4K_CHECK_EN.
- Defined: an INCR burst whose last beat address falls in a different 4 KiB page from the start address is illegal and takes the ERR path (len+1 SLVERR beats, no memory access). The check is computed in IDLE at AR acceptance.
- Undefined: no page check; such bursts are served normally and the address simply increments across the page.

Test Plan:
- INCR, addr=0x100, len=3, size=3, id=5, zero-wait memory, r_ready=1 -> mem addresses 0x100,0x108,0x110,0x118; 4 beats, resp=00, id=5, last only on beat 4; ar_ready back to 1 one cycle after the last handshake.
- FIXED, addr=0x40, len=2 -> three mem requests, all at 0x40; 3 OKAY beats.
- WRAP burst, len=1 -> mem_req never asserted; 2 beats, resp=10, data=0, last on beat 2.
- r_ready_i low for 5 cycles on beat 2 of a len=3 INCR -> r_valid stays 1 and data/last/id remain stable; no new mem_req until the handshake.
- mem_gnt delayed 3 cycles and rvalid delayed 2 cycles after grant -> mem_addr stable through stall; correct data returned; beat count unchanged.
- Reset asserted in WAIT of a len=7 burst, then a late mem_rvalid -> r_valid_o stays 0; ar_ready_o=1 after reset release; next AR is served normally.
- (AXI_R_GEN_4K_CHECK_EN defined) INCR, addr=0xFF8, len=1, size=3 -> 2 SLVERR beats, no mem_req. (Macro undefined) -> OKAY beats at 0xFF8 and 0x1000.

Source files
------------

// File: rtl/axi_r_gen.sv
// AXI4 read-response generator: serves one AR burst at a time, one memory read per R beat.
// Optional macro AXI_R_GEN_4K_CHECK_EN turns INCR bursts that cross a 4 KiB page into SLVERR bursts.
module axi_r_gen #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ar_valid_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [2:0]            ar_size_i,
    input  logic [1:0]            ar_burst_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [USER_WIDTH-1:0] ar_user_i,
    output logic                  ar_ready_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [USER_WIDTH-1:0] r_user_o,
    output logic                  r_last_o,
    input  logic                  r_ready_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, ERR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  is_last;
    logic                  page_cross;
    logic                  ar_illegal;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign is_last   = (cnt_q == len_q);
    assign step      = ADDR_WIDTH'(1) << size_q;
    // INCR realigns to the beat size before stepping, so an unaligned start catches up on beat two
    assign next_addr = (burst_q == 2'b01) ? ((addr_q & ~(step - ADDR_WIDTH'(1))) + step) : addr_q;

`ifdef AXI_R_GEN_4K_CHECK_EN
    logic [ADDR_WIDTH-1:0] ar_mask;
    logic [ADDR_WIDTH-1:0] ar_last_addr;

    assign ar_mask      = (ADDR_WIDTH'(1) << ar_size_i) - ADDR_WIDTH'(1);
    assign ar_last_addr = (ar_addr_i & ~ar_mask) + (ADDR_WIDTH'(ar_len_i) << ar_size_i);
    assign page_cross   = (ar_burst_i == 2'b01) &&
                          (ar_last_addr[ADDR_WIDTH-1:12] != ar_addr_i[ADDR_WIDTH-1:12]);
`else
    assign page_cross   = 1'b0;
`endif

    assign ar_illegal = ar_burst_i[1] || (ar_size_i > MAX_SIZE) || page_cross;

    assign ar_ready_o = (state_q == IDLE);
    assign r_valid_o  = (state_q == SEND) || (state_q == ERR);
    assign r_last_o   = r_valid_o && is_last;
    assign r_resp_o   = (state_q == ERR) ? 2'b10 : 2'b00;
    assign r_data_o   = data_q;
    assign r_id_o     = id_q;
    assign r_user_o   = user_q;
    assign mem_req_o  = (state_q == REQ);
    assign mem_addr_o = addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ar_valid_i) state_d = ar_illegal ? ERR : REQ;
            REQ:  if (mem_gnt_i) state_d = WAIT;
            WAIT: if (mem_rvalid_i) state_d = SEND;
            SEND: if (r_ready_i) state_d = is_last ? IDLE : REQ;
            ERR:  if (r_ready_i && is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst context and beat data; data is cleared on acceptance so the error path returns zeros
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            id_q    <= '0;
            user_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_valid_i) begin
                        addr_q  <= ar_addr_i;
                        len_q   <= ar_len_i;
                        size_q  <= ar_size_i;
                        burst_q <= ar_burst_i;
                        id_q    <= ar_id_i;
                        user_q  <= ar_user_i;
                        cnt_q   <= '0;
                        data_q  <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) data_q <= mem_rdata_i;
                end
                SEND: begin
                    if (r_ready_i && !is_last) begin
                        cnt_q  <= cnt_q + 8'd1;
                        addr_q <= next_addr;
                    end
                end
                ERR: begin
                    if (r_ready_i && !is_last) cnt_q <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_r_gen.sv
// Directed self-checking bench for axi_r_gen with a delay-configurable memory responder.
// Expected beat data is {addr, ~addr} as produced by the responder for each granted address.
module tb_axi_r_gen;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ar_valid_i;
    logic [31:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [2:0]  ar_size_i;
    logic [1:0]  ar_burst_i;
    logic [3:0]  ar_id_i;
    logic [5:0]  ar_user_i;
    logic        ar_ready_o;
    logic        r_valid_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic [3:0]  r_id_o;
    logic [5:0]  r_user_o;
    logic        r_last_o;
    logic        r_ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    axi_r_gen #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .USER_WIDTH(6)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
        .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
        .ar_user_i(ar_user_i), .ar_ready_o(ar_ready_o),
        .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
        .r_id_o(r_id_o), .r_user_o(r_user_o), .r_last_o(r_last_o), .r_ready_i(r_ready_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int gnt_delay = 0;
    int rvalid_delay = 0;
    int req_count = 0;
    int rvalid_count = 0;
    int addr_unstable = 0;
    int stall_bad = 0;
    logic [31:0] req_log[$];

    logic [63:0] bd[256];
    logic [1:0]  br[256];
    logic [3:0]  bi[256];
    logic [5:0]  bu[256];
    logic        bl[256];
    int          bw[256];

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input int stride, input int k);
        if (stride == 0 || k == 0) return base;
        return (base & ~(32'(stride) - 32'd1)) + 32'(k * stride);
    endfunction

    // Memory responder: grants after gnt_delay cycles, returns data rvalid_delay cycles after the cycle following grant
    initial begin
        int waited;
        int rv_cnt;
        bit pending;
        bit req_seen;
        logic [31:0] held_addr;
        logic [63:0] held_data;
        waited = 0; rv_cnt = 0; pending = 0; req_seen = 0;
        held_addr = '0; held_data = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            if (pending) begin
                if (rv_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = held_data;
                    pending = 0;
                    rvalid_count++;
                end else begin
                    rv_cnt--;
                end
            end else if (mem_req_o) begin
                if (req_seen && mem_addr_o !== held_addr) addr_unstable++;
                held_addr = mem_addr_o;
                req_seen = 1;
                if (waited >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    waited = 0;
                    req_seen = 0;
                    held_data = mem_word(mem_addr_o);
                    req_log.push_back(mem_addr_o);
                    req_count++;
                    pending = 1;
                    rv_cnt = rvalid_delay;
                end else begin
                    waited++;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                  input logic [1:0] burst, input logic [3:0] id, input logic [5:0] user);
        int n;
        @(negedge clk_i);
        ar_addr_i = addr; ar_len_i = len; ar_size_i = size;
        ar_burst_i = burst; ar_id_i = id; ar_user_i = user;
        ar_valid_i = 1'b1;
        n = 0;
        while (!ar_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) check_output("ar_ready_timeout", 64'(ar_ready_o), 64'd1);
        @(negedge clk_i);
        ar_valid_i = 1'b0;
    endtask

    task automatic receive_burst(input int nbeats, input int stall_beat, input int stall_cycles);
        for (int b = 0; b < nbeats; b++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk_i);
                n++;
            end while (!r_valid_o && n < 100);
            if (!r_valid_o) begin
                check_output("r_valid_timeout", 64'(r_valid_o), 64'd1);
                return;
            end
            bw[b] = n; bd[b] = r_data_o; br[b] = r_resp_o;
            bi[b] = r_id_o; bu[b] = r_user_o; bl[b] = r_last_o;
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk_i);
                    if (r_valid_o !== 1'b1 || r_data_o !== bd[b] || r_last_o !== bl[b] ||
                        r_id_o !== bi[b] || mem_req_o !== 1'b0) stall_bad++;
                end
            end
            r_ready_i = 1'b1;
            @(negedge clk_i);
            r_ready_i = 1'b0;
        end
    endtask

    task automatic check_beats(input string tag, input int nbeats, input logic [31:0] base, input int stride,
                               input logic [1:0] resp, input logic [3:0] id, input logic [5:0] user);
        for (int b = 0; b < nbeats; b++) begin
            logic [63:0] exp_data;
            exp_data = (resp == 2'b10) ? 64'd0 : mem_word(beat_addr(base, stride, b));
            check_output($sformatf("%s_b%0d_data", tag, b), bd[b], exp_data);
            check_output($sformatf("%s_b%0d_resp", tag, b), 64'(br[b]), 64'(resp));
            check_output($sformatf("%s_b%0d_id", tag, b), 64'(bi[b]), 64'(id));
            check_output($sformatf("%s_b%0d_user", tag, b), 64'(bu[b]), 64'(user));
            check_output($sformatf("%s_b%0d_last", tag, b), 64'(bl[b]), 64'(b == nbeats - 1));
        end
    endtask

    task automatic check_reqs(input string tag, input int n, input logic [31:0] base, input int stride);
        check_output({tag, "_req_count"}, 64'(req_count), 64'(n));
        for (int k = 0; k < n; k++) begin
            logic [31:0] got;
            got = (k < req_log.size()) ? req_log[k] : 32'hxxxx_xxxx;
            check_output($sformatf("%s_req%0d_addr", tag, k), 64'(got), 64'(beat_addr(base, stride, k)));
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_count = 0;
        stall_bad = 0;
        addr_unstable = 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int rv_before;
        int seen_valid;
        int seen_req;
        int lasts;
        rst_ni = 1'b0; ar_valid_i = 1'b0; r_ready_i = 1'b0;
        ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0; ar_id_i = '0; ar_user_i = '0;

        // Reset values
        repeat (3) @(negedge clk_i);
        check_output("rst_ar_ready", 64'(ar_ready_o), 64'd1);
        check_output("rst_r_valid", 64'(r_valid_o), 64'd0);
        check_output("rst_r_last", 64'(r_last_o), 64'd0);
        check_output("rst_r_resp", 64'(r_resp_o), 64'd0);
        check_output("rst_r_data", r_data_o, 64'd0);
        check_output("rst_r_id_user", 64'({r_id_o, r_user_o}), 64'd0);
        check_output("rst_mem_req", 64'(mem_req_o), 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        rst_ni = 1'b1;

        // INCR 0x100 len=3 size=3, zero-wait memory
        clear_logs();
        apply_stimulus(32'h100, 8'd3, 3'd3, 2'b01, 4'd5, 6'h2A);
        check_output("incr_req_cycle1", 64'(mem_req_o), 64'd1);
        receive_burst(4, -1, 0);
        check_output("incr_ar_ready_after", 64'(ar_ready_o), 64'd1);
        check_beats("incr", 4, 32'h100, 8, 2'b00, 4'd5, 6'h2A);
        check_reqs("incr", 4, 32'h100, 8);
        for (int b = 0; b < 4; b++) check_output($sformatf("incr_b%0d_latency", b), 64'(bw[b]), 64'd2);

        // FIXED 0x40 len=2
        clear_logs();
        apply_stimulus(32'h40, 8'd2, 3'd3, 2'b00, 4'd3, 6'h11);
        receive_burst(3, -1, 0);
        check_beats("fixed", 3, 32'h40, 0, 2'b00, 4'd3, 6'h11);
        check_reqs("fixed", 3, 32'h40, 0);

        // WRAP is illegal: SLVERR beats, no memory access
        clear_logs();
        apply_stimulus(32'h80, 8'd1, 3'd3, 2'b10, 4'd7, 6'h05);
        receive_burst(2, -1, 0);
        check_beats("wrap", 2, 32'h80, 0, 2'b10, 4'd7, 6'h05);
        check_output("wrap_req_count", 64'(req_count), 64'd0);
        check_output("wrap_ar_ready_after", 64'(ar_ready_o), 64'd1);

        // Oversized beat (16 bytes on a 64-bit bus) is illegal
        clear_logs();
        apply_stimulus(32'h90, 8'd0, 3'd4, 2'b01, 4'd2, 6'h3F);
        receive_burst(1, -1, 0);
        check_beats("size", 1, 32'h90, 0, 2'b10, 4'd2, 6'h3F);
        check_output("size_req_count", 64'(req_count), 64'd0);

        // R backpressure for 5 cycles on beat 2
        clear_logs();
        apply_stimulus(32'h180, 8'd3, 3'd3, 2'b01, 4'd9, 6'h01);
        receive_burst(4, 1, 5);
        check_output("stall_stable", 64'(stall_bad), 64'd0);
        check_beats("stall", 4, 32'h180, 8, 2'b00, 4'd9, 6'h01);
        check_reqs("stall", 4, 32'h180, 8);

        // Slow memory, unaligned start address
        clear_logs();
        gnt_delay = 3; rvalid_delay = 2;
        apply_stimulus(32'h304, 8'd1, 3'd3, 2'b01, 4'd4, 6'h22);
        receive_burst(2, -1, 0);
        check_output("slow_addr_stable", 64'(addr_unstable), 64'd0);
        check_beats("slow", 2, 32'h304, 8, 2'b00, 4'd4, 6'h22);
        check_reqs("slow", 2, 32'h304, 8);

        // Reset while waiting for read data; the late rvalid must be discarded
        clear_logs();
        gnt_delay = 0; rvalid_delay = 6;
        rv_before = rvalid_count;
        apply_stimulus(32'h200, 8'd7, 3'd3, 2'b01, 4'd6, 6'h0C);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_output("abort_rst_ar_ready", 64'(ar_ready_o), 64'd1);
        check_output("abort_rst_r_valid", 64'(r_valid_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        seen_valid = 0; seen_req = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (r_valid_o !== 1'b0) seen_valid++;
            if (mem_req_o !== 1'b0) seen_req++;
        end
        check_output("abort_no_r_valid", 64'(seen_valid), 64'd0);
        check_output("abort_no_mem_req", 64'(seen_req), 64'd0);
        check_output("abort_late_rvalid_sent", 64'(rvalid_count - rv_before), 64'd1);
        check_output("abort_ar_ready", 64'(ar_ready_o), 64'd1);
        clear_logs();
        rvalid_delay = 0;
        apply_stimulus(32'h500, 8'd1, 3'd3, 2'b01, 4'd9, 6'h15);
        receive_burst(2, -1, 0);
        check_beats("after_rst", 2, 32'h500, 8, 2'b00, 4'd9, 6'h15);
        check_reqs("after_rst", 2, 32'h500, 8);

        // INCR that crosses a 4 KiB page
        clear_logs();
        apply_stimulus(32'hFF8, 8'd1, 3'd3, 2'b01, 4'd1, 6'h02);
        receive_burst(2, -1, 0);
`ifdef AXI_R_GEN_4K_CHECK_EN
        check_beats("page", 2, 32'hFF8, 0, 2'b10, 4'd1, 6'h02);
        check_output("page_req_count", 64'(req_count), 64'd0);
`else
        check_beats("page", 2, 32'hFF8, 8, 2'b00, 4'd1, 6'h02);
        check_reqs("page", 2, 32'hFF8, 8);
`endif

        // Longest burst: 256 byte-sized beats
        clear_logs();
        apply_stimulus(32'h0, 8'd255, 3'd0, 2'b01, 4'd15, 6'h30);
        receive_burst(256, -1, 0);
        lasts = 0;
        for (int b = 0; b < 256; b++) if (bl[b] === 1'b1) lasts++;
        check_output("len255_last_count", 64'(lasts), 64'd1);
        check_output("len255_last_beat", 64'(bl[255]), 64'd1);
        check_beats("len255", 256, 32'h0, 1, 2'b00, 4'd15, 6'h30);
        check_output("len255_req_count", 64'(req_count), 64'd256);
        check_output("len255_ar_ready_after", 64'(ar_ready_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
